// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction-fetch stage feeding the decode stage.
//
// Holds the fetch PC, issues in-order word requests to instruction memory,
// buffers returned words with their PCs in a DEPTH-entry FIFO and presents
// the FIFO head to decode. A redirect from execute reloads the PC, flushes
// the FIFO and arranges for responses already in flight to be discarded.
//
// Parameters
//   RESET_PC  fetch PC loaded on reset
//   DEPTH     FIFO entries = max requests in flight plus buffered (2..8, pow2)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ifu_mem_req_*            request channel to instruction memory (valid/ready)
//   mem_ifu_rsp_*            in-order responses, no backpressure
//   ex_ifu_redirect[_pc]     single-cycle redirect pulse and target
//   if_id_valid/id_ifu_ready handshake towards decode
//   id_inst, pc_id_pc        FIFO head (NOP and 0 when empty)
//
// Optional build macro IFU_PERF_EN adds the ifu_perf_fetched and
// ifu_perf_dropped response counters.
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_mem_req_valid,
   input  logic        ifu_mem_req_ready,
   output logic [31:0] ifu_mem_req_addr,
   input  logic        mem_ifu_rsp_valid,
   input  logic [31:0] mem_ifu_rsp_data,
   input  logic        ex_ifu_redirect,
   input  logic [31:0] ex_ifu_redirect_pc,
   output logic        if_id_valid,
   input  logic        id_ifu_ready,
   output logic [31:0] id_inst,
   output logic [31:0] pc_id_pc
`ifdef IFU_PERF_EN
   ,
   output logic [31:0] ifu_perf_fetched,
   output logic [31:0] ifu_perf_dropped
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [CW:0]   sum_t;

   localparam cnt_t CNT_ONE = cnt_t'(1);
   localparam ptr_t PTR_ONE = ptr_t'(1);

   logic [31:0] pc;
   logic [31:0] resp_pc;
   cnt_t        outstanding;
   cnt_t        drop_cnt;
   cnt_t        count;
   ptr_t        rd_ptr;
   ptr_t        wr_ptr;
   logic [31:0] fifo_inst [DEPTH];
   logic [31:0] fifo_pc   [DEPTH];

   logic issue;
   logic rsp_live;
   logic push;
   logic pop;

   // Credit rule: a request is only issued if its response is guaranteed a
   // FIFO slot, so the FIFO can never overflow and memory never needs
   // backpressure.
   assign ifu_mem_req_valid = !rst && !ex_ifu_redirect &&
                              ((sum_t'(outstanding) + sum_t'(count)) < sum_t'(DEPTH));
   assign ifu_mem_req_addr  = pc;

   assign issue    = ifu_mem_req_valid && ifu_mem_req_ready;
   // A response with nothing outstanding cannot belong to us; ignore it.
   assign rsp_live = mem_ifu_rsp_valid && (outstanding != '0);
   assign push     = rsp_live && !ex_ifu_redirect && (drop_cnt == '0);
   assign pop      = if_id_valid && id_ifu_ready && !ex_ifu_redirect;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its inputs, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         // Issue and response in the same cycle cancel out.
         if (issue && !rsp_live)
            outstanding <= outstanding + CNT_ONE;
         else if (!issue && rsp_live)
            outstanding <= outstanding - CNT_ONE;

         if (ex_ifu_redirect) begin
            pc      <= ex_ifu_redirect_pc & ~32'h3;
            resp_pc <= ex_ifu_redirect_pc & ~32'h3;
            // Everything still in flight after this cycle is wrong-path; the
            // old drop_cnt is a subset of outstanding, so it is absorbed here.
            drop_cnt <= rsp_live ? (outstanding - CNT_ONE) : outstanding;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (issue)
               pc <= pc + 32'd4;
            if (rsp_live && (drop_cnt != '0))
               drop_cnt <= drop_cnt - CNT_ONE;
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
               wr_ptr  <= wr_ptr + PTR_ONE;
            end
            if (pop)
               rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
               count <= count + CNT_ONE;
            else if (!push && pop)
               count <= count - CNT_ONE;
         end
      end
   end

   // NOTE: the FIFO storage has no reset; count gates every read, so stale
   // contents are never visible and the array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_inst[wr_ptr] <= mem_ifu_rsp_data;
         fifo_pc[wr_ptr]   <= resp_pc;
      end
   end

   assign if_id_valid = (count != '0);
   assign id_inst     = if_id_valid ? fifo_inst[rd_ptr] : NOP;
   assign pc_id_pc    = if_id_valid ? fifo_pc[rd_ptr]   : 32'h0;

`ifdef IFU_PERF_EN
   logic rsp_drop;

   // Discarded either by the pending drop count or by a coincident redirect.
   assign rsp_drop = rsp_live && (ex_ifu_redirect || (drop_cnt != '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         ifu_perf_fetched <= '0;
         ifu_perf_dropped <= '0;
      end else begin
         if (push)
            ifu_perf_fetched <= ifu_perf_fetched + 32'd1;
         if (rsp_drop)
            ifu_perf_dropped <= ifu_perf_dropped + 32'd1;
      end
   end
`endif

endmodule
